// File: rtl/apb_bus_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin arbitration, SETUP/ACCESS
// sequencing, response return and pready timeout.
module apb_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*32-1:0]         req_wdata,
  input  logic [NUM_REQ*4-1:0]          req_strb,
  output logic [NUM_REQ-1:0]            ack,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          psel1,
  output logic                          penable,
  output logic                          pwrite,
  output logic [31:0]                   pwdata,
  output logic [3:0]                    pstrb,
  input  logic                          pready,
  input  logic [31:0]                   prdata,
  input  logic                          pslverr
);

  localparam int unsigned GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           win;
  logic                    found;
  logic [NUM_REQ-1:0]      masked;
  logic [TW-1:0]           tcnt;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    win_write;
  logic [31:0]             win_wdata;
  logic [3:0]              win_strb;

  // A requester being acked this cycle cannot be re-granted before it drops req.
  assign masked = req & ~ack;

  // Round-robin search from last_grant+1; descending loop leaves the nearest hit.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (masked[GW'((int'(last_grant) + i) % NUM_REQ)]) begin
        win   = GW'((int'(last_grant) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  // Select the winner's transfer fields.
  always_comb begin
    win_addr  = '0;
    win_write = 1'b0;
    win_wdata = '0;
    win_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == win) begin
        win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_write = req_write[i];
        win_wdata = req_wdata[i*32 +: 32];
        win_strb  = req_strb[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      tcnt       <= '0;
      ack        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      paddr      <= '0;
      psel1      <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= win;
            last_grant <= win;
            paddr      <= win_addr;
            pwrite     <= win_write;
            pwdata     <= win_wdata;
            pstrb      <= win_write ? win_strb : 4'h0;
            psel1      <= 1'b1;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes precedence over a timeout expiring in the same cycle
          if (pready) begin
            ack       <= NUM_REQ'(1) << grant;
            rsp_rdata <= pwrite ? 32'h0 : prdata;
            rsp_err   <= pslverr;
            psel1     <= 1'b0;
            penable   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if ((TIMEOUT != 0) && (tcnt == TW'(TLAST))) begin
            ack       <= NUM_REQ'(1) << grant;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
            psel1     <= 1'b0;
            penable   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter: a transaction-level model predicts the bus
// phases and pushes expected responses; a monitor pops them on every ack.
module tb_apb_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int TO = 15;

  logic              pclk = 1'b0;
  logic              preset_n;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_write;
  logic [N*32-1:0]   req_wdata;
  logic [N*4-1:0]    req_strb;
  logic [N-1:0]      ack;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [AW-1:0]     paddr;
  logic              psel1;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  apb_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel1(psel1), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Requester-side transaction holders
  logic          rq [N];
  logic [AW-1:0] ra [N];
  logic          rw [N];
  logic [31:0]   rd [N];
  logic [3:0]    rs [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]               = rq[i];
      req_write[i]         = rw[i];
      req_addr[i*AW +: AW] = ra[i];
      req_wdata[i*32 +: 32] = rd[i];
      req_strb[i*4 +: 4]   = rs[i];
    end
  end

  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];

  // Model state: phase 0 idle, 1 setup, 2 access
  int          m_ph, m_who, m_acc, m_last, m_ack;
  logic [AW-1:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;
  // Slave plan for the current transfer
  int          s_wait;
  logic [31:0] s_data;
  logic        s_err;
  // Directed overrides
  bit          f_on, rand_on;
  int          f_wait;
  logic [31:0] f_data;
  logic        f_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic set_txn(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    ra[i] = a; rw[i] = w; rd[i] = d; rs[i] = s; rq[i] = 1'b1;
  endtask

  task automatic new_txn(input int i);
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0: a = AW'(10'h005);
      1: a = AW'(10'h006);
      2: a = AW'(10'h007);
      default: a = AW'($urandom);
    endcase
    set_txn(i, a, 1'($urandom), $urandom, 4'($urandom));
  endtask

  function automatic int pick_wait();
    case ($urandom_range(0, 8))
      0, 1, 2: return 0;
      3: return 1;
      4: return 2;
      5: return 3;
      6: return TO - 1;
      7: return TO;
      default: return 20;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({ack, rsp_err, busy, psel1, penable, pwrite, pstrb}), 32'h0);
    check({tag, "_paddr"}, 32'(paddr), 32'h0);
    check({tag, "_pwdata"}, pwdata, 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  // One cycle: compare bus with model, drive inputs, advance model across the edge.
  task automatic step();
    int nxt;
    check("phase", 32'({psel1, penable, busy}), 32'({m_ph != 0, m_ph == 2, m_ph != 0}));
    if (m_ph != 0) begin
      check("paddr", 32'(paddr), 32'(m_addr));
      check("pwrite", 32'(pwrite), 32'(m_write));
      check("pwdata", pwdata, m_wdata);
      check("pstrb", 32'(pstrb), 32'(m_write ? m_strb : 4'h0));
    end

    if (rand_on) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack == i) begin
          if ($urandom_range(0, 1) == 1) new_txn(i);
          else rq[i] = 1'b0;
        end else if (m_ph != 0 && m_who == i) begin
          if (rq[i] && $urandom_range(0, 7) == 0) rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          new_txn(i);
        end
      end
    end

    if (m_ph == 2) begin
      pready  = (m_acc == s_wait);
      prdata  = pready ? s_data : $urandom;
      pslverr = pready ? s_err : 1'($urandom);
    end else begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end

    nxt = -1;
    if (!preset_n) begin
      m_ph   = 0;
      m_last = N - 1;
    end else begin
      case (m_ph)
        0: begin
          for (int j = 1; j <= N; j++) begin
            int c;
            c = (m_last + j) % N;
            if (m_ph == 0 && rq[c] && c != m_ack) begin
              m_ph = 1; m_who = c; m_last = c;
              m_addr = ra[c]; m_write = rw[c]; m_wdata = rd[c]; m_strb = rs[c];
              if (f_on) begin
                s_wait = f_wait; s_data = f_data; s_err = f_err;
              end else begin
                s_wait = pick_wait(); s_data = $urandom; s_err = ($urandom_range(0, 4) == 0);
              end
            end
          end
        end
        1: begin
          m_ph = 2; m_acc = 0;
        end
        default: begin
          if (m_acc == s_wait) begin
            q.push_back('{m_who, m_write ? 32'h0 : s_data, s_err, cyc + 1});
            m_ph = 0; nxt = m_who;
          end else if (m_acc + 1 == TO) begin
            q.push_back('{m_who, 32'h0, 1'b1, cyc + 1});
            m_ph = 0; nxt = m_who;
          end else begin
            m_acc++;
          end
        end
      endcase
    end
    m_ack = nxt;
    @(negedge pclk);
  endtask

  // Response monitor: pops one expectation per ack pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      #1;
      if (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_missing: no ack for requester %0d, required in cycle %0d (now %0d)",
                 q[0].who, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (ack !== '0) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ack_unexpected: got ack %b, required none (cycle %0d)", ack, cyc);
        end else begin
          e = q.pop_front();
          check("ack_onehot", 32'(ack), 32'(1) << e.who);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("ack_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    preset_n = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i] = 1'b0; ra[i] = '0; rw[i] = 1'b0; rd[i] = '0; rs[i] = '0;
    end
    m_ph = 0; m_who = 0; m_acc = 0; m_last = N - 1; m_ack = -1;
    m_addr = '0; m_write = 1'b0; m_wdata = '0; m_strb = '0;
    s_wait = 0; s_data = '0; s_err = 1'b0;
    f_on = 1'b1; rand_on = 1'b0; f_wait = 0; f_data = '0; f_err = 1'b0;
    @(negedge pclk);
    step(); step();
    check_zero("reset");
    preset_n = 1'b1;

    // Single zero-wait write from requester 0
    set_txn(0, 10'h005, 1'b1, 32'hA5A5_1234, 4'hF);
    f_wait = 0; f_data = 32'hDEAD_BEEF; f_err = 1'b0;
    step(); rq[0] = 1'b0;
    repeat (5) step();

    // Read with two wait states; strobes must be suppressed
    set_txn(1, 10'h006, 1'b0, 32'h1111_2222, 4'hF);
    f_wait = 2; f_data = 32'h0000_003C;
    step(); rq[1] = 1'b0;
    repeat (7) step();

    // Contention: both held for four transfers
    set_txn(0, 10'h005, 1'b1, 32'h0000_00AA, 4'h3);
    set_txn(1, 10'h007, 1'b0, 32'h0000_00BB, 4'hC);
    f_wait = 0; f_data = 32'h1234_5678;
    repeat (12) step();
    rq[0] = 1'b0; rq[1] = 1'b0;
    repeat (4) step();

    // Timeout, then a normal transfer
    set_txn(0, 10'h007, 1'b1, 32'hCAFE_F00D, 4'hF);
    f_wait = 1000;
    step(); rq[0] = 1'b0;
    repeat (20) step();
    set_txn(1, 10'h005, 1'b0, 32'h0, 4'h0);
    f_wait = 1; f_data = 32'h0BAD_CAFE;
    step(); rq[1] = 1'b0;
    repeat (6) step();

    // Slave error followed by a clean transfer
    set_txn(0, 10'h006, 1'b1, 32'h5555_AAAA, 4'h5);
    f_wait = 0; f_err = 1'b1;
    step(); rq[0] = 1'b0;
    repeat (4) step();
    set_txn(1, 10'h006, 1'b0, 32'h0, 4'hF);
    f_err = 1'b0; f_data = 32'h7777_0001;
    step(); rq[1] = 1'b0;
    repeat (4) step();

    // Reset while in ACCESS; requester 0 must win first afterwards
    set_txn(0, 10'h006, 1'b0, 32'h0, 4'h0);
    f_wait = 1000;
    step(); rq[0] = 1'b0;
    repeat (3) step();
    preset_n = 1'b0;
    step();
    check_zero("midrst");
    preset_n = 1'b1;
    set_txn(0, 10'h005, 1'b1, 32'h0000_0F0F, 4'hA);
    set_txn(1, 10'h007, 1'b1, 32'h0000_F0F0, 4'h5);
    f_wait = 0;
    step(); rq[0] = 1'b0;
    repeat (4) step();
    rq[1] = 1'b0;
    repeat (6) step();

    // Randomized traffic
    f_on = 1'b0; rand_on = 1'b1;
    repeat (3000) step();

    // Drain
    rand_on = 1'b0;
    for (int i = 0; i < N; i++) rq[i] = 1'b0;
    repeat (40) step();
    check("drain_queue", 32'(q.size()), 32'h0);
    check("drain_idle", 32'({psel1, penable, busy}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
